// File: rtl/cpu_flag_ctrl.sv
// cpu_flag_ctrl: picks next C/Z/B for cpu_mreg, keeps an IRQ flag shadow
// stack and evaluates branch conditions against the current flags.
// Ports: CLK, RST (sync, active-high); C/Z/B fed back from cpu_mreg;
//   alu_valid/alu_c/alu_z/alu_b; fop_valid/fop; push/pop; cond;
//   out: Cin/Zin/Bin, cond_true, level, full, empty, ovf, unf, coll.
module cpu_flag_ctrl #(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          C,
  input  logic          Z,
  input  logic          B,
  input  logic          alu_valid,
  input  logic          alu_c,
  input  logic          alu_z,
  input  logic          alu_b,
  input  logic          fop_valid,
  input  logic [2:0]    fop,
  input  logic          push,
  input  logic          pop,
  input  logic [2:0]    cond,
  output logic          Cin,
  output logic          Zin,
  output logic          Bin,
  output logic          cond_true,
  output logic [PW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf,
  output logic          coll
);

  localparam logic [PW:0] LMAX = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE  = (PW+1)'(1);

  logic [2:0]    stk [DEPTH];
  logic [PW:0]   lvl;
  logic [PW-1:0] top;
  logic [PW-1:0] wr;
  logic          do_push;
  logic          do_pop;
  logic [2:0]    nxt;

  assign full    = (lvl == LMAX);
  assign empty   = (lvl == '0);
  assign level   = lvl;
  assign top     = PW'(lvl - ONE);
  assign wr      = PW'(lvl);
  // a simultaneous push+pop cancels both
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;

  always_comb begin
    nxt = {C, Z, B};
    if (RST) begin
      nxt = 3'b000;
    end else if (do_pop) begin
      nxt = stk[top];
    end else if (fop_valid && fop != 3'b000) begin
      unique case (fop)
        3'b001:  nxt[2] = 1'b1;
        3'b010:  nxt[2] = 1'b0;
        3'b011:  nxt[0] = 1'b1;
        3'b100:  nxt[0] = 1'b0;
        3'b101:  nxt[1] = 1'b0;
        3'b110:  nxt    = 3'b000;
        3'b111:  nxt[1] = 1'b1;
        default: nxt    = {C, Z, B};
      endcase
    end else if (alu_valid) begin
      nxt = {alu_c, alu_z, alu_b};
    end
  end

  assign {Cin, Zin, Bin} = nxt;

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      3'b000: cond_true = 1'b1;
      3'b001: cond_true = C;
      3'b010: cond_true = ~C;
      3'b011: cond_true = Z;
      3'b100: cond_true = ~Z;
      3'b101: cond_true = B;
      3'b110: cond_true = ~B;
      3'b111: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lvl  <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
      coll <= 1'b0;
    end else begin
      if (do_push)
        lvl <= lvl + ONE;
      else if (do_pop)
        lvl <= lvl - ONE;
      if (push & pop)
        coll <= 1'b1;
      if (push & ~pop & full)
        ovf <= 1'b1;
      if (pop & ~push & empty)
        unf <= 1'b1;
    end
  end

  // contents need no reset; only level decides what is valid
  always_ff @(posedge CLK) begin
    if (!RST && do_push)
      stk[wr] <= {C, Z, B};
  end

endmodule
